point_bit_streamer: RTL and testbench
=====================================

// Module: point_bit_streamer
// PURPOSE
//  Serializer feeding the bit-serial distance unit (BDU). Accepts one query/reference 3-D point
//  pair in parallel. Emits them as interleaved bit streams, MSB plane first, in x,y,z order,
//  with the dimension code and the plane shift amount. Honours the BDU early-termination
//  signal so that a pruned pair frees the lane at once.
// PARAMETERS
//  B      32  bits per dimension (2..64; which_bit is 7 bits wide)
//  TAG_W  8   width of the opaque pair tag carried through to completion
// PORTS
//  clk         in   1      clock
//  rst         in   1      reset, synchronous, active-high
//  in_valid    in   1      point pair offered
//  in_ready    out  1      streamer can accept a pair
//  q_x,q_y,q_z in   B      query point coordinates (unsigned)
//  r_x,r_y,r_z in   B      reference point coordinates (unsigned)
//  in_tag      in   TAG_W  pair identifier
//  q_bit       out  1      current query bit
//  r_bit       out  1      current reference bit
//  code        out  2      01=x, 10=y, 11=z, 00=idle/no bit
//  which_bit   out  7      2*p, where p = plane index (0 = MSB plane)
//  terminate   in   1      from BDU: partial distance already exceeds threshold
//  done        out  1      one-cycle pulse: pair finished
//  done_early  out  1      valid with done: 1 = aborted by terminate
//  done_tag    out  TAG_W  valid with done: tag of the finished pair
//  busy        out  1      state != IDLE
// BEHAVIOUR
//  - FSM states: IDLE, STREAM, FIN.
//    IDLE: in_ready=1. On in_valid&&in_ready, latch the six coordinates and in_tag, set p=0,
//    dim=x, and go to STREAM.
//  - STREAM: one bit per cycle. q_bit=q_dim[B-1-p], r_bit=r_dim[B-1-p], code=dim, which_bit=2*p.
//    dim steps x->y->z->x; p increments after z.
//    The first bit appears in the cycle after the accept. The stream is exactly 3*B beats,
//    ending at p=B-1, dim=z, then go to FIN.
//  - FIN: done=1, done_tag=latched tag, done_early set as described below; next cycle IDLE.
//    Throughput is one pair per 3*B+2 cycles. in_ready=0 outside IDLE.
//  - Outputs are registered. Outside STREAM: code=00, q_bit=r_bit=0, which_bit=0.
//  - p counter is $clog2(B)+1 bits and never wraps: the STREAM->FIN exit occurs before any wrap.
//    The which_bit computation is zero-extended to 7 bits.
//  - Reset (any state, including mid-stream): state=IDLE, in_ready=1 on the following cycle.
//    Reset clears all of: code, q_bit, r_bit, which_bit, done, done_early, done_tag, busy, p, dim.
//    A partially streamed pair is discarded; no done is produced for it.
//  - terminate is ignored in IDLE and in FIN.
// CONFIGURATION
//  EARLY_TERM_EN defined:
//    - terminate=1 sampled in STREAM -> next cycle FIN with done_early=1; no further bits issue.
//    - terminate on the final beat (p=B-1, dim=z) counts as normal completion: done_early=0.
//  EARLY_TERM_EN undefined:
//    - terminate is unused; every pair streams all 3*B beats; done_early is tied 0.
// STRUCTURE
//  - knn_pkg holds:
//    - B_DEFAULT;
//    - typedef enum logic[1:0] dim_code_e {DIM_NONE=2'b00, DIM_X=2'b01, DIM_Y=2'b10, DIM_Z=2'b11};
//    - typedef enum for the FSM states;
//    - typedef struct point3_t {x,y,z}.
//  - One sub-module: plane_mux. It is combinational and selects coordinate bit [B-1-p] for a
//    given dim; it is instantiated twice, once for q and once for r.
//  - Top level holds the FSM, the counters and the latches.
// TESTING (B=4, TAG_W=8 unless noted)
//  1. q=(A,3,F), r=(0,0,0), tag=5A.
//     -> q_bit sequence 1,0,1, 0,0,1, 1,1,1, 0,1,1.
//     -> code 01,10,11 repeating; which_bit 0,0,0,2,2,2,4,4,4,6,6,6.
//     -> done at beat 13 after accept; done_tag=5A; done_early=0.
//  2. EARLY_TERM_EN: same pair, terminate=1 during beat 4.
//     -> code=00 from beat 5; done at beat 5 with done_early=1.
//     Without the macro: 12 beats stream, done_early=0.
//  3. terminate=1 exactly on beat 12 (p=3, z) -> done_early=0, done_tag correct.
//  4. rst asserted at beat 6 -> next cycle code=00, busy=0, in_ready=1, no done.
//     A fresh pair then streams correctly from p=0.
//  5. in_valid held high for back-to-back pairs (tags 01, 02).
//     -> second accept 14 cycles after the first; in_ready=0 throughout beats 1..13.
//  6. B=32, q=(FFFFFFFF,0,0), r=(0,FFFFFFFF,0) -> 96 beats.
//     -> every x beat q=1,r=0; every y beat q=0,r=1; last which_bit=62.

Source files
------------

// File: rtl/knn_pkg.sv
// ---------------------------------------------------------------------------
// knn_pkg
// Shared types for the k-NN bit-serial datapath:
//   B_DEFAULT   default coordinate width
//   B_MAX       widest coordinate the point3_t container can hold
//   WB_W        width of the which_bit plane-shift output
//   dim_code_e  dimension code driven alongside each serial bit
//   state_e     point streamer FSM states
//   point3_t    3-D point; coordinates narrower than B_MAX sit in the LSBs
//   next_dim()  x -> y -> z -> x dimension rotation
// ---------------------------------------------------------------------------
package knn_pkg;

    localparam int B_DEFAULT = 32;
    localparam int B_MAX     = 64;
    localparam int WB_W      = 7;

    typedef enum logic [1:0] {
        DIM_NONE = 2'b00,
        DIM_X    = 2'b01,
        DIM_Y    = 2'b10,
        DIM_Z    = 2'b11
    } dim_code_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_STREAM = 2'b01,
        ST_FIN    = 2'b10
    } state_e;

    typedef struct packed {
        logic [B_MAX-1:0] x;
        logic [B_MAX-1:0] y;
        logic [B_MAX-1:0] z;
    } point3_t;

    function automatic dim_code_e next_dim(input dim_code_e d);
        case (d)
            DIM_X:   return DIM_Y;
            DIM_Y:   return DIM_Z;
            default: return DIM_X;
        endcase
    endfunction

endpackage

// File: rtl/point_bit_streamer_plane_mux.sv
// ---------------------------------------------------------------------------
// plane_mux
// Combinational bit-plane selector: returns bit [B-1-p] of the coordinate
// picked by i_dim. DIM_NONE yields 0.
// Ports:
//   i_pt   in  point3_t   point holding the three coordinates
//   i_p    in  PW         plane index, 0 = MSB plane
//   i_dim  in  dim_code_e dimension to read
//   o_bit  out 1          selected bit
// ---------------------------------------------------------------------------
module plane_mux
    import knn_pkg::*;
#(
    parameter int B  = B_DEFAULT,
    parameter int PW = $clog2(B) + 1
) (
    input  point3_t         i_pt,
    input  logic [PW-1:0]   i_p,
    input  dim_code_e       i_dim,
    output logic            o_bit
);

    // Plane 0 is the MSB, so the physical bit index counts down from B-1.
    logic [5:0] w_idx;
    assign w_idx = 6'(B - 1) - 6'(i_p);

    always_comb begin
        o_bit = 1'b0;
        case (i_dim)
            DIM_X:   o_bit = i_pt.x[w_idx];
            DIM_Y:   o_bit = i_pt.y[w_idx];
            DIM_Z:   o_bit = i_pt.z[w_idx];
            default: o_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/point_bit_streamer.sv
// ---------------------------------------------------------------------------
// point_bit_streamer
// Serializes one query/reference 3-D point pair into interleaved bit streams
// for the bit-serial distance unit: MSB plane first, x,y,z within a plane.
// Each beat carries the dimension code and the plane shift (2*p).
// Optional feature macro: EARLY_TERM_EN -- when defined, terminate from the
// distance unit ends the stream early and flags done_early; when undefined,
// terminate is unused and done_early is tied low.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      pair handshake (ready only in IDLE)
//   q_x,q_y,q_z,r_x,r_y,r_z  query / reference coordinates, B bits each
//   in_tag                   opaque pair tag
//   q_bit, r_bit             current serial bits
//   code                     01=x 10=y 11=z 00=no bit
//   which_bit                2*plane index
//   terminate                early-termination request from the distance unit
//   done, done_early, done_tag  one-cycle completion pulse with status/tag
//   busy                     FSM not idle
// ---------------------------------------------------------------------------
module point_bit_streamer
    import knn_pkg::*;
#(
    parameter int B     = B_DEFAULT,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [B-1:0]     q_x,
    input  logic [B-1:0]     q_y,
    input  logic [B-1:0]     q_z,
    input  logic [B-1:0]     r_x,
    input  logic [B-1:0]     r_y,
    input  logic [B-1:0]     r_z,
    input  logic [TAG_W-1:0] in_tag,
    output logic             q_bit,
    output logic             r_bit,
    output logic [1:0]       code,
    output logic [WB_W-1:0]  which_bit,
    input  logic             terminate,
    output logic             done,
    output logic             done_early,
    output logic [TAG_W-1:0] done_tag,
    output logic             busy
);

    localparam int            PW     = $clog2(B) + 1;
    localparam logic [PW-1:0] P_LAST = PW'(B - 1);

    state_e           r_state, w_state_nxt;
    logic [PW-1:0]    r_p, w_p_nxt;
    dim_code_e        r_dim, w_dim_nxt;
    logic             w_accept;
    point3_t          r_q, r_r, w_q_src, w_r_src;
    logic [TAG_W-1:0] r_tag;
    logic             w_q_bit, w_r_bit;

    logic             r_q_bit, r_r_bit, r_done;
    logic [1:0]       r_code;
    logic [WB_W-1:0]  r_which;
    logic [TAG_W-1:0] r_done_tag;

`ifdef EARLY_TERM_EN
    logic             w_early;
`endif

    // ---- next-state: r_p/r_dim always describe the beat shown this cycle ----
    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_dim_nxt   = r_dim;
        w_accept    = 1'b0;
`ifdef EARLY_TERM_EN
        w_early     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_STREAM;
                    w_p_nxt     = '0;
                    w_dim_nxt   = DIM_X;
                end
            end
            ST_STREAM: begin
                // Final beat wins over terminate: that is a normal completion.
                if (r_p == P_LAST && r_dim == DIM_Z) begin
                    w_state_nxt = ST_FIN;
                end
`ifdef EARLY_TERM_EN
                else if (terminate) begin
                    w_state_nxt = ST_FIN;
                    w_early     = 1'b1;
                end
`endif
                else begin
                    w_dim_nxt = next_dim(r_dim);
                    if (r_dim == DIM_Z) begin
                        w_p_nxt = r_p + PW'(1);
                    end
                end
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // On the accept cycle the first beat must come straight from the inputs,
    // since the coordinate latches only load at that same edge.
    always_comb begin
        if (w_accept) begin
            w_q_src.x = B_MAX'(q_x);
            w_q_src.y = B_MAX'(q_y);
            w_q_src.z = B_MAX'(q_z);
            w_r_src.x = B_MAX'(r_x);
            w_r_src.y = B_MAX'(r_y);
            w_r_src.z = B_MAX'(r_z);
        end else begin
            w_q_src = r_q;
            w_r_src = r_r;
        end
    end

    plane_mux #(.B(B), .PW(PW)) u_q_mux (
        .i_pt  (w_q_src),
        .i_p   (w_p_nxt),
        .i_dim (w_dim_nxt),
        .o_bit (w_q_bit)
    );

    plane_mux #(.B(B), .PW(PW)) u_r_mux (
        .i_pt  (w_r_src),
        .i_p   (w_p_nxt),
        .i_dim (w_dim_nxt),
        .o_bit (w_r_bit)
    );

    // ---- control and registered outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_p        <= '0;
            r_dim      <= DIM_NONE;
            r_code     <= DIM_NONE;
            r_q_bit    <= 1'b0;
            r_r_bit    <= 1'b0;
            r_which    <= '0;
            r_done     <= 1'b0;
            r_done_tag <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_dim   <= w_dim_nxt;
            if (w_state_nxt == ST_STREAM) begin
                r_code  <= w_dim_nxt;
                r_q_bit <= w_q_bit;
                r_r_bit <= w_r_bit;
                r_which <= WB_W'(w_p_nxt) << 1;
            end else begin
                r_code  <= DIM_NONE;
                r_q_bit <= 1'b0;
                r_r_bit <= 1'b0;
                r_which <= '0;
            end
            r_done     <= (w_state_nxt == ST_FIN);
            r_done_tag <= (w_state_nxt == ST_FIN) ? r_tag : '0;
        end
    end

    // ---- pair latches (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q   <= w_q_src;
            r_r   <= w_r_src;
            r_tag <= in_tag;
        end
    end

`ifdef EARLY_TERM_EN
    logic r_done_early;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_early <= 1'b0;
        end else begin
            r_done_early <= w_early;
        end
    end
    assign done_early = r_done_early;
`else
    logic w_unused_term;
    assign w_unused_term = terminate;
    assign done_early    = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign code      = r_code;
    assign q_bit     = r_q_bit;
    assign r_bit     = r_r_bit;
    assign which_bit = r_which;
    assign done      = r_done;
    assign done_tag  = r_done_tag;

endmodule

// File: tb/tb_point_bit_streamer.sv
module tb_point_bit_streamer;

    localparam int B     = 4;
    localparam int TAG_W = 8;
    localparam int NB    = 3 * B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, in_valid, in_ready, terminate;
    logic [B-1:0]     q_x, q_y, q_z, r_x, r_y, r_z;
    logic [TAG_W-1:0] in_tag, done_tag;
    logic             q_bit, r_bit, done, done_early, busy;
    logic [1:0]       code;
    logic [6:0]       which_bit;

    point_bit_streamer #(.B(B), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .q_x(q_x), .q_y(q_y), .q_z(q_z), .r_x(r_x), .r_y(r_y), .r_z(r_z),
        .in_tag(in_tag), .q_bit(q_bit), .r_bit(r_bit), .code(code),
        .which_bit(which_bit), .terminate(terminate), .done(done),
        .done_early(done_early), .done_tag(done_tag), .busy(busy)
    );

    // Wide instance for the full-width stream
    logic             v32, rdy32, t32, qb32, rb32, dn32, de32, busy32;
    logic [31:0]      qx32, qy32, qz32, rx32, ry32, rz32;
    logic [TAG_W-1:0] tag32, dtag32;
    logic [1:0]       code32;
    logic [6:0]       wb32;

    point_bit_streamer #(.B(32), .TAG_W(TAG_W)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
        .q_x(qx32), .q_y(qy32), .q_z(qz32), .r_x(rx32), .r_y(ry32), .r_z(rz32),
        .in_tag(tag32), .q_bit(qb32), .r_bit(rb32), .code(code32),
        .which_bit(wb32), .terminate(t32), .done(dn32),
        .done_early(de32), .done_tag(dtag32), .busy(busy32)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct { bit q; bit r; bit [1:0] code; bit [6:0] wb; bit last; } beat_t;
    typedef struct { bit [TAG_W-1:0] tag; bit early; } done_t;

    beat_t beat_q[$];
    done_t done_q[$];
    bit    expect_done = 1'b0;
    bit    mon_en      = 1'b0;

    // Reference: beat t streams plane t/3 of dimension t%3; early stop after
    // beat k when enabled and k is not the final beat.
    function automatic int beats_for(input int k);
        int n;
        n = NB;
`ifdef EARLY_TERM_EN
        if (k >= 1 && k < NB) n = k;
`endif
        return n;
    endfunction

    task automatic model_push(input logic [2:0][B-1:0] qc, input logic [2:0][B-1:0] rc,
                              input logic [TAG_W-1:0] tag, input int k);
        int    n, p, d;
        beat_t b;
        done_t dn;
        n = beats_for(k);
        for (int t = 0; t < n; t++) begin
            p      = t / 3;
            d      = t % 3;
            b.q    = qc[d][B-1-p];
            b.r    = rc[d][B-1-p];
            b.code = 2'(d + 1);
            b.wb   = 7'(2 * p);
            b.last = (t == n - 1);
            beat_q.push_back(b);
        end
        dn.tag   = tag;
        dn.early = (n != NB);
        done_q.push_back(dn);
    endtask

    // Monitor: pops expected beats/completions whenever the DUT presents them
    always @(negedge clk) begin
        if (mon_en) begin
            if (expect_done) begin
                done_t dn;
                chk("done_pulse", done, 1);
                chk("done_code_idle", code, 0);
                chk("done_q_size", done_q.size() > 0, 1);
                if (done_q.size() > 0) begin
                    dn = done_q.pop_front();
                    chk("done_tag", done_tag, dn.tag);
                    chk("done_early", done_early, dn.early);
                end
                expect_done = 1'b0;
            end else if (done) begin
                chk("unexpected_done", done, 0);
            end
            if (code != 2'b00) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", code, 0);
                end else begin
                    beat_t b;
                    b = beat_q.pop_front();
                    chk("q_bit", q_bit, b.q);
                    chk("r_bit", r_bit, b.r);
                    chk("code", code, b.code);
                    chk("which_bit", which_bit, b.wb);
                    if (b.last) expect_done = 1'b1;
                end
            end
        end
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before_send", in_ready, 1);
    endtask

    task automatic send(input logic [2:0][B-1:0] qc, input logic [2:0][B-1:0] rc,
                        input logic [TAG_W-1:0] tag, input int k);
        int n;
        wait_ready();
        n = beats_for(k);
        model_push(qc, rc, tag, k);
        {q_z, q_y, q_x} = qc;
        {r_z, r_y, r_x} = rc;
        in_tag    = tag;
        in_valid  = 1'b1;
        terminate = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        in_valid  = 1'b0;
        chk("first_beat_code", code, 2'b01);
        chk("first_beat_which", which_bit, 0);
        for (int j = 1; j <= n; j++) begin
            terminate = (j == k);
            @(posedge clk); #1;
        end
        terminate = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        terminate = 1'b0;
        chk("ready_after_done", in_ready, 1);
        chk("busy_after_done", busy, 0);
    endtask

    logic [2:0][B-1:0] qa, ra, qb, rb;

    initial begin
        rst = 1'b1; in_valid = 1'b0; terminate = 1'b0; in_tag = '0;
        {q_z, q_y, q_x} = '0; {r_z, r_y, r_x} = '0;
        v32 = 1'b0; t32 = 1'b0; tag32 = '0;
        qx32 = '0; qy32 = '0; qz32 = '0; rx32 = '0; ry32 = '0; rz32 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", code, 0);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_done_tag", done_tag, 0);
        chk("rst_done_early", done_early, 0);
        chk("rst_which", which_bit, 0);
        chk("rst_qr_bits", {q_bit, r_bit}, 0);
        chk("rst32_code", code32, 0);
        chk("rst32_ready", rdy32, 1);
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Reference pair q=(A,3,F), r=0
        qa = {4'hF, 4'h3, 4'hA};
        ra = '0;
        send(qa, ra, 8'h5A, 0);
        send(qa, ra, 8'h5A, 4);
        send(qa, ra, 8'h5A, NB);

        // Reset mid-stream at beat 6
        wait_ready();
        model_push(qa, ra, 8'h77, 0);
        {q_z, q_y, q_x} = qa; {r_z, r_y, r_x} = ra; in_tag = 8'h77;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("beat6_code", code, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat_q.delete(); done_q.delete(); expect_done = 1'b0;
        chk("midrst_code", code, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        chk("midrst_done", done, 0);
        chk("midrst_which", which_bit, 0);
        @(posedge clk); #1;
        chk("midrst_no_done", done, 0);
        send({4'h5, 4'hC, 4'h9}, {4'h6, 4'h1, 4'hE}, 8'h33, 0);

        // Back-to-back with in_valid held high
        qa = {4'h1, 4'h2, 4'h4}; ra = {4'h8, 4'h7, 4'h6};
        qb = {4'hE, 4'hD, 4'hB}; rb = {4'h3, 4'h9, 4'h0};
        wait_ready();
        model_push(qa, ra, 8'h01, 0);
        model_push(qb, rb, 8'h02, 0);
        {q_z, q_y, q_x} = qa; {r_z, r_y, r_x} = ra; in_tag = 8'h01;
        in_valid = 1'b1;
        @(posedge clk); #1;
        {q_z, q_y, q_x} = qb; {r_z, r_y, r_x} = rb; in_tag = 8'h02;
        for (int i = 1; i <= 13; i++) begin
            chk("b2b_ready_low", in_ready, 0);
            @(posedge clk); #1;
        end
        chk("b2b_ready_c14", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_second_accept", code, 2'b01);
        repeat (13) @(posedge clk);
        #1;

        // Full-width instance: q=(FFFFFFFF,0,0), r=(0,FFFFFFFF,0)
        qx32 = 32'hFFFF_FFFF; ry32 = 32'hFFFF_FFFF; tag32 = 8'hC3;
        v32 = 1'b1;
        @(posedge clk); #1;
        v32 = 1'b0;
        for (int t = 0; t < 96; t++) begin
            chk("w32_q", qb32, (t % 3) == 0);
            chk("w32_r", rb32, (t % 3) == 1);
            chk("w32_code", code32, (t % 3) + 1);
            if (t == 95) chk("w32_last_which", wb32, 62);
            @(posedge clk); #1;
        end
        chk("w32_done", dn32, 1);
        chk("w32_done_tag", dtag32, 8'hC3);
        chk("w32_done_early", de32, 0);

        // Randomized pairs
        for (int n = 0; n < 40; n++) begin
            qa = 12'($urandom); ra = 12'($urandom);
            send(qa, ra, 8'($urandom), $urandom_range(0, NB + 2));
            repeat ($urandom_range(0, 3)) begin
                terminate = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            terminate = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("beat_q_drained", beat_q.size(), 0);
        chk("done_q_drained", done_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
